// File: rtl/glitchless_mux_n.sv
// rtl/glitchless_mux_n.sv - N-way registered mux with break-before-make channel switching
// Build option: GLITCHLESS_MUX_HOLD_EN holds mux_out through the switch bubble instead of zeroing it.
module glitchless_mux_n #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int DEAD = 2,
    localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  mux_in,
    input  logic [SW-1:0]   sel_req,
    input  logic            sel_valid,
    output logic            sel_ready,
    output logic [W-1:0]    mux_out,
    output logic            out_valid,
    output logic [SW-1:0]   cur_sel,
    output logic            sel_err
);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_BREAK  = 2'd1,
        S_MAKE   = 2'd2
    } state_t;

`ifdef GLITCHLESS_MUX_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [SW-1:0]   cur_sel_q, cur_sel_d;
    logic [SW-1:0]   pending_q, pending_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [W-1:0]    mux_out_q, mux_out_d;
    logic            out_valid_q, out_valid_d;
    logic            sel_err_q, sel_err_d;
    logic            sel_ready_q, sel_ready_d;

    logic [SW-1:0]   data_idx;
    logic [W-1:0]    sel_data;
    logic [W-1:0]    bubble_data;
    logic            req_oob;

    // The MAKE edge already registers the pending channel, so the bubble is DEAD+1 cycles.
    always_comb begin
        data_idx = (state_q == S_MAKE) ? pending_q : cur_sel_q;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (data_idx == SW'(k)) begin
                sel_data = mux_in[k*W +: W];
            end
        end
    end

    assign bubble_data = HOLD ? mux_out_q : '0;
    assign req_oob     = (int'(sel_req) >= N);

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        mux_out_d   = mux_out_q;
        out_valid_d = out_valid_q;
        sel_err_d   = 1'b0;

        case (state_q)
            S_ACTIVE: begin
                mux_out_d   = sel_data;
                out_valid_d = 1'b1;
                if (sel_valid && sel_ready_q) begin
                    if (req_oob) begin
                        sel_err_d = 1'b1;
                    end else if (sel_req != cur_sel_q) begin
                        pending_d   = sel_req;
                        cnt_d       = 4'(DEAD - 1);
                        state_d     = S_BREAK;
                        out_valid_d = 1'b0;
                        mux_out_d   = bubble_data;
                    end
                end
            end
            S_BREAK: begin
                out_valid_d = 1'b0;
                mux_out_d   = bubble_data;
                if (cnt_q == 4'd0) begin
                    state_d = S_MAKE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_MAKE: begin
                cur_sel_d   = pending_q;
                mux_out_d   = sel_data;
                out_valid_d = 1'b1;
                state_d     = S_ACTIVE;
            end
            default: begin
                state_d = S_ACTIVE;
            end
        endcase

        sel_ready_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACTIVE;
            cur_sel_q   <= '0;
            pending_q   <= '0;
            cnt_q       <= '0;
            mux_out_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            sel_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            mux_out_q   <= mux_out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            sel_ready_q <= sel_ready_d;
        end
    end

    assign sel_ready = sel_ready_q;
    assign mux_out   = mux_out_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_glitchless_mux_n.sv
// tb/tb_glitchless_mux_n.sv - scoreboard bench for glitchless_mux_n (N=4/DEAD=2 and N=3/DEAD=1)
module tb_glitchless_mux_n;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] a_in;
    logic [1:0]  a_req;
    logic        a_valid;
    logic        a_ready;
    logic [7:0]  a_out;
    logic        a_ov;
    logic [1:0]  a_cs;
    logic        a_err;

    logic [23:0] b_in;
    logic [1:0]  b_req;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  b_out;
    logic        b_ov;
    logic [1:0]  b_cs;
    logic        b_err;

    glitchless_mux_n #(.W(8), .N(4), .DEAD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .mux_in(a_in), .sel_req(a_req), .sel_valid(a_valid),
        .sel_ready(a_ready), .mux_out(a_out), .out_valid(a_ov), .cur_sel(a_cs), .sel_err(a_err)
    );

    glitchless_mux_n #(.W(8), .N(3), .DEAD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mux_in(b_in), .sel_req(b_req), .sel_valid(b_valid),
        .sel_ready(b_ready), .mux_out(b_out), .out_valid(b_ov), .cur_sel(b_cs), .sel_err(b_err)
    );

`ifdef GLITCHLESS_MUX_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    typedef struct {
        int         dut;
        int         cyc;
        string      name;
        logic [7:0] mo;
        logic       ov;
        logic [1:0] cs;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expectation describes the outputs after the next rising edge.
    task automatic expect_out(input int dut, input string name, input logic [7:0] mo,
                              input logic ov, input logic [1:0] cs, input logic rdy, input logic err);
        exp_t e;
        e.dut = dut; e.cyc = cyc + 1; e.name = name;
        e.mo = mo; e.ov = ov; e.cs = cs; e.rdy = rdy; e.err = err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] mo;
            logic       ov, rdy, err;
            logic [1:0] cs;
            e = q.pop_front();
            if (e.dut == 0) begin
                mo = a_out; ov = a_ov; cs = a_cs; rdy = a_ready; err = a_err;
            end else begin
                mo = b_out; ov = b_ov; cs = b_cs; rdy = b_ready; err = b_err;
            end
            n_cmp++;
            if (e.cyc != cyc || mo !== e.mo || ov !== e.ov || cs !== e.cs || rdy !== e.rdy || err !== e.err) begin
                n_bad++;
                $display("FAIL %s (dut%0d cyc %0d/%0d): got mux_out=%h out_valid=%b cur_sel=%0d sel_ready=%b sel_err=%b, want mux_out=%h out_valid=%b cur_sel=%0d sel_ready=%b sel_err=%b",
                         e.name, e.dut, cyc, e.cyc, mo, ov, cs, rdy, err, e.mo, e.ov, e.cs, e.rdy, e.err);
            end
        end
    end

    initial begin
        logic [7:0] a_bub;
        logic [7:0] b_bub;
        int         wait_cnt;

        rst_n   = 1'b0;
        a_in    = {8'h77, 8'h3C, 8'h11, 8'hA5};
        b_in    = {8'h0F, 8'hC3, 8'h5A};
        a_req   = '0; a_valid = 1'b0;
        b_req   = '0; b_valid = 1'b0;
        a_bub   = HOLD ? 8'hA5 : 8'h00;

        tick();
        expect_out(0, "reset_state", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        expect_out(0, "reset_release", 8'hA5, 1'b1, 2'd0, 1'b1, 1'b0);
        expect_out(1, "b_reset_release", 8'h5A, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();

        // Switch 0 -> 2; ch0 changes mid-bubble and must not leak out.
        a_req = 2'd2; a_valid = 1'b1;
        expect_out(0, "break1", a_bub, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        a_valid = 1'b0;
        a_in[7:0] = 8'hFF;
        expect_out(0, "break2", a_bub, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out(0, "make", a_bub, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out(0, "switched", 8'h3C, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        a_in[7:0] = 8'hA5;
        expect_out(0, "switched_hold", 8'h3C, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();

        // Same-channel request held high: no bubble, data tracks with 1-cycle latency.
        a_req = 2'd2; a_valid = 1'b1;
        a_in[23:16] = 8'h44;
        expect_out(0, "same_sel1", 8'h44, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out(0, "same_sel2", 8'h44, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();

        // Start switch to 3 and abort with reset in the second BREAK cycle.
        a_req = 2'd3;
        a_bub = HOLD ? 8'h44 : 8'h00;
        expect_out(0, "abort_break1", a_bub, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        a_valid = 1'b0;
        expect_out(0, "abort_break2", a_bub, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        expect_out(0, "abort_reset", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        expect_out(0, "abort_release", 8'hA5, 1'b1, 2'd0, 1'b1, 1'b0);
        expect_out(1, "b_release", 8'h5A, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out(0, "abort_no_pending1", 8'hA5, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out(0, "abort_no_pending2", 8'hA5, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();

        // N=3: out-of-range request pulses sel_err once, no bubble.
        b_req = 2'd3; b_valid = 1'b1;
        expect_out(1, "oob_err", 8'h5A, 1'b1, 2'd0, 1'b1, 1'b1);
        tick();
        b_valid = 1'b0;
        expect_out(1, "oob_err_clear", 8'h5A, 1'b1, 2'd0, 1'b1, 1'b0);
        tick();

        // N=3, DEAD=1: two-cycle bubble on switch 0 -> 2.
        b_bub = HOLD ? 8'h5A : 8'h00;
        b_req = 2'd2; b_valid = 1'b1;
        expect_out(1, "b_break", b_bub, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        b_valid = 1'b0;
        expect_out(1, "b_make", b_bub, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out(1, "b_switched", 8'h0F, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        b_req = 2'd3; b_valid = 1'b1;
        expect_out(1, "b_oob_from2", 8'h0F, 1'b1, 2'd2, 1'b1, 1'b1);
        tick();
        b_valid = 1'b0;
        expect_out(1, "b_oob_from2_clear", 8'h0F, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glitchless_mux_n.md
GLITCHLESS_MUX_N -- requirements
Module: glitchless_mux_n

Interface
REQ-001 SHALL provide parameter W, default 8, data width per channel in bits (1..64).
REQ-002 SHALL provide parameter N, default 4, channel count (2..16); SW = clog2(N).
REQ-003 SHALL provide parameter DEAD, default 2, break-before-make dead time in clocks (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mux_in  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
REQ-007 SHALL have port sel_req  input  SW  requested channel index.
REQ-008 SHALL have port sel_valid  input  1  select request strobe.
REQ-009 SHALL have port sel_ready  output  1  block can accept a select request.
REQ-010 SHALL have port mux_out  output  W  registered selected data.
REQ-011 SHALL have port out_valid  output  1  mux_out reflects cur_sel.
REQ-012 SHALL have port cur_sel  output  SW  currently connected channel.
REQ-013 SHALL have port sel_err  output  1  one-cycle pulse on rejected request.

Function
REQ-014 SHALL implement FSM states ACTIVE, BREAK, MAKE; encoding is free.
REQ-015 SHALL accept a request only on a clk edge with sel_valid=1 and sel_ready=1.
REQ-016 SHALL drive sel_ready=1 in ACTIVE only, 0 in BREAK and MAKE.
REQ-017 In ACTIVE, SHALL register mux_out <= channel cur_sel each cycle (1-cycle latency) with out_valid=1.
REQ-018 On an accepted request with sel_req != cur_sel and sel_req < N, SHALL latch sel_req into a pending register and enter BREAK next cycle.
REQ-019 On an accepted request with sel_req == cur_sel, SHALL stay in ACTIVE with no bubble and no sel_err.
REQ-020 On an accepted request with sel_req >= N (non-power-of-two N), SHALL stay in ACTIVE, leave cur_sel unchanged, and pulse sel_err for exactly one cycle.
REQ-021 In BREAK, SHALL drive out_valid=0 for exactly DEAD cycles via a 4-bit down-counter, then enter MAKE.
REQ-022 In MAKE (1 cycle), SHALL load cur_sel <= pending, keep out_valid=0, then enter ACTIVE.
REQ-023 First ACTIVE cycle after MAKE SHALL register data of the new channel; out_valid rises on that edge.
REQ-024 Total bubble per switch SHALL be DEAD+1 cycles of out_valid=0; no cycle SHALL show mixed old/new channel data with out_valid=1.
REQ-025 sel_valid held high SHALL be treated as a new request each time sel_ready is 1 (no edge detection).
REQ-026 mux_in changes during BREAK/MAKE SHALL have no effect on FSM timing.

Reset
REQ-027 While rst_n=0 at a clk edge: state=ACTIVE, cur_sel=0, pending=0, counter=0, mux_out=0, out_valid=0, sel_err=0.
REQ-028 sel_ready SHALL be 0 while rst_n=0 and 1 from the first edge after rst_n returns high.
REQ-029 First edge with rst_n=1 SHALL register channel 0 and set out_valid=1.
REQ-030 Reset asserted in BREAK or MAKE SHALL abort the switch; the pending select SHALL be discarded.

Configuration
REQ-031 Macro GLITCHLESS_MUX_HOLD_EN SHALL be the only compile-time option.
REQ-032 With GLITCHLESS_MUX_HOLD_EN defined, mux_out SHALL hold its last ACTIVE value through BREAK and MAKE.
REQ-033 Without it, mux_out SHALL be forced to 0 on the first BREAK edge and held at 0 through MAKE.
REQ-034 out_valid, sel_ready, and FSM timing SHALL be identical in both builds.

Verification
REQ-035 Reset release, W=8, N=4, mux_in ch0=8'hA5 -> one edge later mux_out=8'hA5, out_valid=1, cur_sel=0, sel_ready=1.
REQ-036 Request sel_req=2 (ch2=8'h3C), DEAD=2 -> out_valid=0 for 3 cycles, sel_ready=0 for those cycles, then mux_out=8'h3C, cur_sel=2.
REQ-037 Request sel_req equal to cur_sel -> out_valid stays 1, zero bubble, sel_err=0.
REQ-038 N=3, sel_req=3 -> sel_err high for 1 cycle, cur_sel unchanged, no bubble.
REQ-039 rst_n=0 in the second BREAK cycle -> after release cur_sel=0, out_valid=1; the pending channel is never selected.
REQ-040 Run REQ-036 in both builds -> during the bubble mux_out=8'hA5 with GLITCHLESS_MUX_HOLD_EN and 8'h00 without it.
